// File: rtl/des_key_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_key_sequencer_pkg                                                |
// | Shared encodings and widths for the DES key-schedule sequencer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package des_key_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2
    } state_t;

    localparam int NROUNDS = 16;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int W_KEY    = 64;
    localparam int W_CD     = 56;
    localparam int W_SUBKEY = 48;

endpackage : des_key_sequencer_pkg
`default_nettype wire

// File: rtl/key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_schedule                                                         |
// | One DES key-schedule round: rotate C and D, then PC2 to a subkey.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module key_schedule
    import des_key_sequencer_pkg::*;
(
    input  logic [W_CD-1:0]     x,
    input  logic [3:0]          i,
    output logic [W_SUBKEY-1:0] k_round,
    output logic [W_CD-1:0]     r_round
);

    localparam int c_pc2 [W_SUBKEY] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    logic        w_single;
    logic [27:0] w_c;
    logic [27:0] w_d;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;

    assign w_single = (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    assign w_c      = x[W_CD-1:28];
    assign w_d      = x[27:0];
    assign w_c_rot  = w_single ? {w_c[26:0], w_c[27]} : {w_c[25:0], w_c[27:26]};
    assign w_d_rot  = w_single ? {w_d[26:0], w_d[27]} : {w_d[25:0], w_d[27:26]};
    assign r_round  = {w_c_rot, w_d_rot};

    generate
        for (genvar j = 0; j < W_SUBKEY; j++) begin : g_pc2
            assign k_round[W_SUBKEY-1-j] = r_round[W_CD-c_pc2[j]];
        end
    endgenerate

endmodule : key_schedule
`default_nettype wire

// File: rtl/perm_PC1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perm_PC1                                                             |
// | DES permuted choice 1: 64-bit key to 56-bit C||D, parity dropped.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module perm_PC1
    import des_key_sequencer_pkg::*;
(
    input  logic [W_KEY-1:0] din,
    output logic [W_CD-1:0]  dout
);

    // DES bit numbering: bit 1 is the MSB of the vector.
    localparam int c_pc1 [W_CD] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    generate
        for (genvar j = 0; j < W_CD; j++) begin : g_pc1
            assign dout[W_CD-1-j] = din[W_KEY-c_pc1[j]];
        end
    endgenerate

endmodule : perm_PC1
`default_nettype wire

// File: rtl/des_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_key_sequencer                                                    |
// | Expands a DES key into 16 buffered subkeys, then streams them in     |
// | encrypt or decrypt order over a valid/ready handshake.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module des_key_sequencer
    import des_key_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                mode,
    input  logic [W_KEY-1:0]    key,
    output logic                busy,
    output logic                k_valid,
    input  logic                k_ready,
    output logic [W_SUBKEY-1:0] k,
    output logic [3:0]          k_idx,
    output logic                done
);

    localparam logic [3:0] c_last = 4'(NROUNDS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W_CD-1:0]     r_x;
    logic                r_mode;
    logic [3:0]          r_cnt;
    logic [3:0]          r_ptr;
    logic [3:0]          r_xfer;
    logic                r_busy;
    logic                r_kvalid;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_fire;
    logic [W_SUBKEY-1:0] r_buf [NROUNDS];
    logic [W_CD-1:0]     w_pc1;
    logic [W_CD-1:0]     w_r_round;
    logic [W_SUBKEY-1:0] w_k_round;

    perm_PC1 u_pc1 (
        .din  (key),
        .dout (w_pc1)
    );

    key_schedule u_ks (
        .x       (r_x),
        .i       (r_cnt),
        .k_round (w_k_round),
        .r_round (w_r_round)
    );

    assign w_fire = r_kvalid & k_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_fire && (r_xfer == c_last)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_kvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_kvalid <= (w_state_nxt == ST_SERVE);
            r_done   <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_mode <= MODE_ENC;
            r_cnt  <= 4'd0;
            r_ptr  <= 4'd0;
            r_xfer <= 4'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_x    <= w_pc1;
                        r_mode <= mode;
                        r_cnt  <= 4'd0;
                    end
                end
                ST_EXPAND: begin
                    r_x <= w_r_round;
                    if (r_cnt == c_last) begin
                        r_ptr  <= (r_mode == MODE_DEC) ? c_last : 4'd0;
                        r_xfer <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_SERVE: begin
                    // Counters hold on the final transfer so ptr stays inside the buffer.
                    if (w_fire && (r_xfer != c_last)) begin
                        r_xfer <= r_xfer + 4'd1;
                        r_ptr  <= (r_mode == MODE_ENC) ? r_ptr + 4'd1 : r_ptr - 4'd1;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_EXPAND) begin
            r_buf[r_cnt] <= w_k_round;
        end
    end

    assign busy    = r_busy;
    assign k_valid = r_kvalid;
    assign done    = r_done;
    assign k       = r_kvalid ? r_buf[r_ptr] : '0;
    assign k_idx   = r_kvalid ? r_ptr : 4'd0;

endmodule : des_key_sequencer
`default_nettype wire

// File: tb/tb_des_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_des_key_sequencer                                                 |
// | Directed bench: ordering, backpressure, ignored req, reset, chaining.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_des_key_sequencer;
    import des_key_sequencer_pkg::*;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        mode;
    logic [63:0] key;
    logic        busy;
    logic        k_valid;
    logic        k_ready;
    logic [47:0] k;
    logic [3:0]  k_idx;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_k   [NROUNDS];
    logic [47:0] got_k   [NROUNDS];
    logic [3:0]  got_idx [NROUNDS];
    int          n_xfer;
    int          n_done_early;
    int          hold_err;
    int          timed_out;
    logic        done_at_end;
    logic        busy_at_end;

    always #5 clk = ~clk;

    des_key_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .key     (key),
        .busy    (busy),
        .k_valid (k_valid),
        .k_ready (k_ready),
        .k       (k),
        .k_idx   (k_idx),
        .done    (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after the capturing edge.
    task automatic start_op(input logic [63:0] kv, input logic m);
        req  = 1'b1;
        key  = kv;
        mode = m;
        @(negedge clk);
        req  = 1'b0;
        key  = ~kv;
        mode = ~m;
    endtask

    // Records transfers until 16 are seen, returning in the cycle after the last one.
    task automatic collect(input int pct, input int req_at);
        logic        pv;
        logic        pr;
        logic [47:0] pk;
        logic [3:0]  pi;
        n_xfer = 0; n_done_early = 0; hold_err = 0; timed_out = 0;
        pv = 1'b0; pr = 1'b1; pk = '0; pi = '0;
        for (int cyc = 0; cyc < 400 && n_xfer < NROUNDS; cyc++) begin
            if (done) n_done_early++;
            if (pv && !pr && (k_valid !== 1'b1 || k !== pk || k_idx !== pi)) hold_err++;
            if (req_at >= 0 && n_xfer == req_at) begin
                req = 1'b1; key = 64'hFFFF_FFFF_FFFF_FFFF; mode = 1'b1;
            end else begin
                req = 1'b0;
            end
            k_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            pv = k_valid; pr = k_ready; pk = k; pi = k_idx;
            if (k_valid && k_ready) begin
                got_k[n_xfer]   = k;
                got_idx[n_xfer] = k_idx;
                n_xfer++;
            end
            @(negedge clk);
        end
        req = 1'b0;
        if (n_xfer < NROUNDS) timed_out = 1;
        done_at_end = done;
        busy_at_end = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; mode = 1'b0; key = '0; k_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (k_valid !== 1'b0) begin bad++; $display("FAIL rst_kvalid: got %b want 0", k_valid); end
        total++; if (k !== 48'h0)      begin bad++; $display("FAIL rst_k: got %h want 0", k); end
        total++; if (k_idx !== 4'd0)   begin bad++; $display("FAIL rst_kidx: got %0d want 0", k_idx); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt;
        k_ready = 1'b1;
        start_op(KEY_A, MODE_ENC);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL enc_busy: got %b want 1", busy); end
        repeat (15) @(negedge clk);
        total++; if (k_valid !== 1'b0) begin bad++; $display("FAIL enc_early_valid: got %b want 0", k_valid); end
        @(negedge clk);
        total++; if (k_valid !== 1'b1) begin bad++; $display("FAIL enc_latency: got %b want 1", k_valid); end
        total++; if (k !== exp_k[0] || k_idx !== 4'd0) begin bad++; $display("FAIL enc_first: got %h/%0d want %h/0", k, k_idx, exp_k[0]); end
        collect(100, -1);
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL enc_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== exp_k[i] || got_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL enc_k[%0d]: got %h/%0d want %h/%0d", i, got_k[i], got_idx[i], exp_k[i], i);
            end
        end
        total++; if (done_at_end !== 1'b1 || n_done_early != 0) begin bad++; $display("FAIL enc_done: got %b early=%0d want 1 early=0", done_at_end, n_done_early); end
        total++; if (busy_at_end !== 1'b0) begin bad++; $display("FAIL enc_busy_end: got %b want 0", busy_at_end); end
        @(negedge clk);
        total++; if (done !== 1'b0 || k_valid !== 1'b0 || k !== 48'h0) begin bad++; $display("FAIL enc_after: got done=%b kv=%b k=%h want 0/0/0", done, k_valid, k); end
    endtask

    task automatic test_decrypt;
        k_ready = 1'b1;
        start_op(KEY_A, MODE_DEC);
        repeat (16) @(negedge clk);
        total++; if (k_valid !== 1'b1 || k !== exp_k[15] || k_idx !== 4'd15) begin bad++; $display("FAIL dec_first: got %b %h/%0d want 1 %h/15", k_valid, k, k_idx, exp_k[15]); end
        collect(100, -1);
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL dec_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== exp_k[15-i] || got_idx[i] !== 4'(15-i)) begin
                bad++; $display("FAIL dec_k[%0d]: got %h/%0d want %h/%0d", i, got_k[i], got_idx[i], exp_k[15-i], 15-i);
            end
        end
        total++; if (done_at_end !== 1'b1) begin bad++; $display("FAIL dec_done: got %b want 1", done_at_end); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        k_ready = 1'b0;
        start_op(KEY_A, MODE_ENC);
        repeat (16) @(negedge clk);
        collect(50, -1);
        total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold: got %0d changes want 0", hold_err); end
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL bp_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== exp_k[i] || got_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL bp_k[%0d]: got %h/%0d want %h/%0d", i, got_k[i], got_idx[i], exp_k[i], i);
            end
        end
        total++; if (done_at_end !== 1'b1 || n_done_early != 0) begin bad++; $display("FAIL bp_done: got %b early=%0d want 1 early=0", done_at_end, n_done_early); end
        k_ready = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_ignored_req;
        k_ready = 1'b1;
        start_op(KEY_A, MODE_ENC);
        repeat (5) @(negedge clk);
        req = 1'b1; key = 64'hFFFF_FFFF_FFFF_FFFF; mode = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        collect(100, 4);
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL ign_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== exp_k[i] || got_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL ign_k[%0d]: got %h/%0d want %h/%0d", i, got_k[i], got_idx[i], exp_k[i], i);
            end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        k_ready = 1'b1;
        start_op(KEY_A, MODE_ENC);
        repeat (7) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmx_pre_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || k_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmx_async: got busy=%b kv=%b done=%b want 0", busy, k_valid, done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmx_idle: got %b want 0", busy); end

        start_op(KEY_A, MODE_ENC);
        repeat (16) @(negedge clk);
        for (int cyc = 0; cyc < 20 && k_idx != 4'd5; cyc++) @(negedge clk);
        total++; if (k_valid !== 1'b1 || k_idx !== 4'd5 || k !== exp_k[5]) begin bad++; $display("FAIL rms_pre: got %b %h/%0d want 1 %h/5", k_valid, k, k_idx, exp_k[5]); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || k_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rms_async_ctl: got busy=%b kv=%b done=%b want 0", busy, k_valid, done); end
        total++; if (k !== 48'h0 || k_idx !== 4'd0) begin bad++; $display("FAIL rms_async_k: got %h/%0d want 0/0", k, k_idx); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_op(KEY_A, MODE_ENC);
        repeat (16) @(negedge clk);
        collect(100, -1);
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL rmf_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== exp_k[i] || got_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL rmf_k[%0d]: got %h/%0d want %h/%0d", i, got_k[i], got_idx[i], exp_k[i], i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        k_ready = 1'b1;
        start_op(KEY_A, MODE_DEC);
        repeat (16) @(negedge clk);
        collect(100, -1);
        total++; if (done_at_end !== 1'b1 || got_k[0] !== exp_k[15]) begin bad++; $display("FAIL b2b_first_op: got done=%b k0=%h want 1 %h", done_at_end, got_k[0], exp_k[15]); end
        start_op(64'h0, MODE_ENC);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done); end
        repeat (15) @(negedge clk);
        total++; if (k_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid: got %b want 0", k_valid); end
        @(negedge clk);
        total++; if (k_valid !== 1'b1) begin bad++; $display("FAIL b2b_latency: got %b want 1", k_valid); end
        collect(100, -1);
        total++; if (timed_out != 0 || n_xfer != NROUNDS) begin bad++; $display("FAIL b2b_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < NROUNDS; i++) begin
            total++;
            if (got_k[i] !== 48'h0 || got_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL b2b_k[%0d]: got %h/%0d want 0/%0d", i, got_k[i], got_idx[i], i);
            end
        end
        total++; if (done_at_end !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done_at_end); end
        @(negedge clk);
    endtask

    initial begin
        exp_k[0]  = 48'h1B02EFFC7072; exp_k[1]  = 48'h79AED9DBC9E5;
        exp_k[2]  = 48'h55FC8A42CF99; exp_k[3]  = 48'h72ADD6DB351D;
        exp_k[4]  = 48'h7CEC07EB53A8; exp_k[5]  = 48'h63A53E507B2F;
        exp_k[6]  = 48'hEC84B7F618BC; exp_k[7]  = 48'hF78A3AC13BFB;
        exp_k[8]  = 48'hE0DBEBEDE781; exp_k[9]  = 48'hB1F347BA464F;
        exp_k[10] = 48'h215FD3DED386; exp_k[11] = 48'h7571F59467E9;
        exp_k[12] = 48'h97C5D1FABA41; exp_k[13] = 48'h5F43B7F2E73A;
        exp_k[14] = 48'hBF918D3D3F0A; exp_k[15] = 48'hCB3D8B0E17F5;

        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_ignored_req();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_des_key_sequencer
`default_nettype wire
